store_align_buffer: RTL and testbench

- Store-side counterpart of the load extraction path.
- Accepts store requests (sw/sh/sb) from the execute stage and aligns the store data into byte lanes.
- Generates per-byte write strobes and flags misaligned accesses.
- Queues stores in a small FIFO and issues them to data memory over a valid/ready handshake, so the core does not stall on a slow memory write.

---
 rtl/store_align_buffer.sv | 128 ++++++++++++
 tb/tb_store_align_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_buffer.sv
// store_align_buffer
//   Store-side byte-lane aligner and write buffer. Incoming sw/sh/sb requests
//   are replicated into byte lanes with matching write strobes. Misaligned
//   requests are dropped and reported. Aligned requests are queued in a small
//   FIFO and drained to data memory over a valid/ready handshake.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   st_valid/st_ready     request handshake from the core
//   st_addr, st_data      byte address, right-justified store data
//   st_sel                000 sw, 001 sb, 010 sh, others treated as sw
//   mem_valid/mem_ready   handshake toward data memory
//   mem_addr              word-aligned address of the head entry
//   mem_wdata, mem_wstrb  lane-aligned data and byte enables of the head entry
//   misalign, err_addr    one-cycle drop pulse, address of last dropped request
//   busy                  buffer holds at least one store
module store_align_buffer #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [2:0]  st_sel,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        misalign,
   output logic [31:0] err_addr,
   output logic        busy
);

   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic [29:0] fifo_addr [0:DEPTH-1];
   logic [31:0] fifo_data [0:DEPTH-1];
   logic [3:0]  fifo_strb [0:DEPTH-1];

   logic        accept;
   logic        bad;
   logic        push;
   logic        pop;
   logic [1:0]  off;
   logic [31:0] al_data;
   logic [3:0]  al_strb;

   assign off = st_addr[1:0];

   always_comb begin
      al_data = st_data;
      al_strb = 4'b1111;
      bad     = (off != 2'b00);
      case (st_sel)
         3'b001: begin
            al_data = {4{st_data[7:0]}};
            al_strb = 4'b0001 << off;
            bad     = 1'b0;
         end
         3'b010: begin
            al_data = {2{st_data[15:0]}};
            al_strb = 4'b0011 << off;
            bad     = off[0];
         end
         default: begin
            al_data = st_data;
            al_strb = 4'b1111;
            bad     = (off != 2'b00);
         end
      endcase
   end

   // Readiness depends only on occupancy, never on mem_ready: no pass-through when full.
   assign st_ready  = (count != CNT_W'(DEPTH));
   assign accept    = st_valid && st_ready;
   assign push      = accept && !bad;
   assign mem_valid = (count != '0);
   assign pop       = mem_valid && mem_ready;
   assign busy      = mem_valid;

   // Head entry is masked to zero when empty so stale slots never leak out.
   assign mem_addr  = mem_valid ? {fifo_addr[rd_ptr], 2'b00} : 32'h0;
   assign mem_wdata = mem_valid ? fifo_data[rd_ptr] : 32'h0;
   assign mem_wstrb = mem_valid ? fifo_strb[rd_ptr] : 4'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         misalign <= 1'b0;
         err_addr <= 32'h0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_addr[i] <= '0;
            fifo_data[i] <= '0;
            fifo_strb[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_addr[wr_ptr] <= st_addr[31:2];
            fifo_data[wr_ptr] <= al_data;
            fifo_strb[wr_ptr] <= al_strb;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         misalign <= accept && bad;
         if (accept && bad) begin
            err_addr <= st_addr;
         end
      end
   end

endmodule

// File: tb/tb_store_align_buffer.sv
// tb_store_align_buffer
//   Directed bench for store_align_buffer: a table of single-store alignment
//   vectors, then hand-written sequences for backpressure, simultaneous
//   push/pop and mid-operation reset.
module tb_store_align_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_sel;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        misalign;
   logic [31:0] err_addr;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   store_align_buffer #(.DEPTH(2), .PTR_W(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_sel    (st_sel),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .misalign  (misalign),
      .err_addr  (err_addr),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] addr;
      logic [31:0] data;
      logic        bad;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_strb;
   } vec_t;

   localparam logic [2:0] SW = 3'b000;
   localparam logic [2:0] SB = 3'b001;
   localparam logic [2:0] SH = 3'b010;

   vec_t vecs [14];

   task automatic push_req(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
      st_valid = 1'b1;
      st_sel   = sel;
      st_addr  = addr;
      st_data  = data;
   endtask

   initial begin
      vecs[0]  = '{SB,     32'h0000_1003, 32'h0000_00AB, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000};
      vecs[1]  = '{SH,     32'h0000_2002, 32'h1234_BEEF, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100};
      vecs[2]  = '{SW,     32'h0000_3001, 32'h1111_2222, 1'b1, 32'h0,         32'h0,         4'b0000};
      vecs[3]  = '{SB,     32'h0000_0040, 32'h1234_5678, 1'b0, 32'h0000_0040, 32'h7878_7878, 4'b0001};
      vecs[4]  = '{SB,     32'h0000_0041, 32'h0000_00CD, 1'b0, 32'h0000_0040, 32'hCDCD_CDCD, 4'b0010};
      vecs[5]  = '{SB,     32'h0000_0042, 32'hFFFF_FF5A, 1'b0, 32'h0000_0040, 32'h5A5A_5A5A, 4'b0100};
      vecs[6]  = '{SH,     32'h0000_0050, 32'hFFFF_1234, 1'b0, 32'h0000_0050, 32'h1234_1234, 4'b0011};
      vecs[7]  = '{SH,     32'h0000_0051, 32'h0000_5555, 1'b1, 32'h0,         32'h0,         4'b0000};
      vecs[8]  = '{SH,     32'h0000_0053, 32'h0000_6666, 1'b1, 32'h0,         32'h0,         4'b0000};
      vecs[9]  = '{SW,     32'h0000_0060, 32'hDEAD_BEEF, 1'b0, 32'h0000_0060, 32'hDEAD_BEEF, 4'b1111};
      vecs[10] = '{SW,     32'h0000_0062, 32'h7777_7777, 1'b1, 32'h0,         32'h0,         4'b0000};
      vecs[11] = '{3'b111, 32'h0000_0070, 32'hCAFE_F00D, 1'b0, 32'h0000_0070, 32'hCAFE_F00D, 4'b1111};
      vecs[12] = '{3'b011, 32'h0000_0071, 32'h8888_8888, 1'b1, 32'h0,         32'h0,         4'b0000};
      vecs[13] = '{3'b100, 32'h8000_007C, 32'h0102_0304, 1'b0, 32'h8000_007C, 32'h0102_0304, 4'b1111};

      reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_sel = '0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_st_ready",  32'(st_ready),  32'd1);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_misalign",  32'(misalign),  32'd0);
      check("rst_err_addr",  err_addr,       32'h0);
      check("rst_mem_addr",  mem_addr,       32'h0);
      check("rst_mem_wdata", mem_wdata,      32'h0);
      check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);

      // Single-store vectors: accept, check presentation, then drain.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         mem_ready = 1'b0;
         push_req(vecs[i].sel, vecs[i].addr, vecs[i].data);
         @(posedge clk);
         @(negedge clk);
         st_valid = 1'b0;
         if (vecs[i].bad) begin
            check($sformatf("v%0d_misalign", i),  32'(misalign),  32'd1);
            check($sformatf("v%0d_err_addr", i),  err_addr,       vecs[i].addr);
            check($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 32'd0);
            check($sformatf("v%0d_busy", i),      32'(busy),      32'd0);
         end else begin
            check($sformatf("v%0d_misalign", i),  32'(misalign),  32'd0);
            check($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 32'd1);
            check($sformatf("v%0d_mem_addr", i),  mem_addr,       vecs[i].e_addr);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata,      vecs[i].e_wdata);
            check($sformatf("v%0d_mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_strb));
            check($sformatf("v%0d_busy", i),      32'(busy),      32'd1);
         end
         mem_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         mem_ready = 1'b0;
         check($sformatf("v%0d_drain_busy", i),     32'(busy),      32'd0);
         check($sformatf("v%0d_drain_valid", i),    32'(mem_valid), 32'd0);
         check($sformatf("v%0d_pulse_end", i),      32'(misalign),  32'd0);
         check($sformatf("v%0d_drain_wstrb", i),    32'(mem_wstrb), 32'h0);
      end
      check("err_addr_hold", err_addr, 32'h0000_0071);

      // Backpressure: three sw with memory stalled, then drain in order.
      @(negedge clk);
      mem_ready = 1'b0;
      push_req(SW, 32'h10, 32'hA000_0010);
      @(posedge clk);
      @(negedge clk);
      check("bp_ready_after1", 32'(st_ready), 32'd1);
      push_req(SW, 32'h14, 32'hA000_0014);
      @(posedge clk);
      @(negedge clk);
      check("bp_ready_after2", 32'(st_ready), 32'd0);
      push_req(SW, 32'h18, 32'hA000_0018);
      @(posedge clk);
      @(negedge clk);
      check("bp_still_full", 32'(st_ready), 32'd0);
      check("bp_head0_addr", mem_addr,  32'h10);
      check("bp_head0_data", mem_wdata, 32'hA000_0010);
      check("bp_head0_strb", 32'(mem_wstrb), 32'hF);
      mem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_head1_addr", mem_addr, 32'h14);
      check("bp_head1_data", mem_wdata, 32'hA000_0014);
      check("bp_ready_freed", 32'(st_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      st_valid = 1'b0;
      check("bp_head2_valid", 32'(mem_valid), 32'd1);
      check("bp_head2_addr", mem_addr, 32'h18);
      check("bp_head2_data", mem_wdata, 32'hA000_0018);
      check("bp_head2_strb", 32'(mem_wstrb), 32'hF);
      @(posedge clk);
      @(negedge clk);
      check("bp_empty", 32'(busy), 32'd0);

      // Simultaneous push and pop at count = 1.
      mem_ready = 1'b0;
      push_req(SW, 32'h100, 32'h0000_0001);
      @(posedge clk);
      @(negedge clk);
      push_req(SW, 32'h104, 32'h0000_0002);
      mem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      st_valid = 1'b0;
      check("sim_valid", 32'(mem_valid), 32'd1);
      check("sim_addr", mem_addr, 32'h104);
      check("sim_data", mem_wdata, 32'h0000_0002);
      check("sim_ready", 32'(st_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("sim_empty", 32'(busy), 32'd0);

      // Reset with two buffered stores.
      mem_ready = 1'b0;
      push_req(SW, 32'h200, 32'hBAD0_0200);
      @(posedge clk);
      @(negedge clk);
      push_req(SB, 32'h205, 32'h0000_00EE);
      @(posedge clk);
      @(negedge clk);
      st_valid = 1'b0;
      check("pre_rst_full", 32'(st_ready), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_valid", 32'(mem_valid), 32'd0);
      check("mid_rst_busy",  32'(busy),      32'd0);
      check("mid_rst_ready", 32'(st_ready),  32'd1);
      mem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("post_rst_idle%0d", c), 32'(mem_valid), 32'd0);
      end
      push_req(SB, 32'h300, 32'h0000_0042);
      @(posedge clk);
      @(negedge clk);
      st_valid = 1'b0;
      check("post_rst_addr",  mem_addr,       32'h300);
      check("post_rst_data",  mem_wdata,      32'h4242_4242);
      check("post_rst_strb",  32'(mem_wstrb), 32'h1);
      @(posedge clk);
      @(negedge clk);
      check("post_rst_empty", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
